actbuf_wr_arb: RTL

Shares one upstream activation-load stream between the NUM_ROWS systolic-block rows of the array. Each row raises an activation-buffer write request. The arbiter picks one row round-robin and issues a fetch command naming that row to the upstream loader. It then forwards exactly BURST_LEN data beats to the granted row as one-hot write-valid strobes on a shared, broadcast data bus. The block sits between the activation loader and the array of rows, in the low-speed clock domain.

---
 rtl/actbuf_wr_arb_if.sv | 32 +++
 rtl/actbuf_wr_arb.sv | 113 +++++++++++
 2 files changed

// File: rtl/actbuf_wr_arb_if.sv
// Bundle of the row-side write port and the loader-side command/data port of the
// activation-buffer write arbiter.
interface actbuf_wr_arb_if #(
  parameter int NUM_ROWS = 4,
  parameter int DATA_W   = 64,
  parameter int ROW_W    = $clog2(NUM_ROWS)
);
  logic [NUM_ROWS-1:0] row_wr_req;
  logic [NUM_ROWS-1:0] row_wr_vld;
  logic [DATA_W-1:0]   row_wr_data;
  logic                src_cmd_vld;
  logic [ROW_W-1:0]    src_cmd_row;
  logic                src_cmd_rdy;
  logic [DATA_W-1:0]   src_data;
  logic                src_valid;
  logic                src_ready;
  logic                busy;
  logic                burst_done;
  logic [ROW_W-1:0]    burst_done_row;

  modport master (
    input  row_wr_req, src_cmd_rdy, src_data, src_valid,
    output row_wr_vld, row_wr_data, src_cmd_vld, src_cmd_row, src_ready,
           busy, burst_done, burst_done_row
  );

  modport slave (
    output row_wr_req, src_cmd_rdy, src_data, src_valid,
    input  row_wr_vld, row_wr_data, src_cmd_vld, src_cmd_row, src_ready,
           busy, burst_done, burst_done_row
  );
endinterface

// File: rtl/actbuf_wr_arb.sv
// Round-robin arbiter sharing one activation-load stream between the array rows:
// grants a row, commands the loader for it, then forwards BURST_LEN beats to it.
module actbuf_wr_arb #(
  parameter int NUM_ROWS  = 4,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16
) (
  input  logic              clk_l,
  input  logic              rst,
  actbuf_wr_arb_if.master   bus
);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE, CMD, STREAM, GAP} state_t;

  state_t              r_state;
  logic [ROW_W-1:0]    r_ptr;
  logic [ROW_W-1:0]    r_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_ROWS-1:0] r_row_wr_vld;
  logic [DATA_W-1:0]   r_row_wr_data;
  logic                r_src_cmd_vld;
  logic [ROW_W-1:0]    r_src_cmd_row;
  logic                r_burst_done;
  logic [ROW_W-1:0]    r_burst_done_row;

  logic                w_win_vld;
  logic [ROW_W-1:0]    w_win_idx;
  logic                w_beat;

  function automatic logic [ROW_W-1:0] rr_idx(input logic [ROW_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_ROWS) s = s - NUM_ROWS;
    return ROW_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (bus.row_wr_req[rr_idx(r_ptr, i)]) begin
        w_win_vld = 1'b1;
        w_win_idx = rr_idx(r_ptr, i);
      end
    end
  end

  assign w_beat = (r_state == STREAM) && bus.src_valid;

  always_ff @(posedge clk_l) begin
    if (rst) begin
      r_state          <= IDLE;
      r_ptr            <= '0;
      r_grant          <= '0;
      r_cnt            <= '0;
      r_row_wr_vld     <= '0;
      r_row_wr_data    <= '0;
      r_src_cmd_vld    <= 1'b0;
      r_src_cmd_row    <= '0;
      r_burst_done     <= 1'b0;
      r_burst_done_row <= '0;
    end else begin
      r_row_wr_vld <= '0;
      r_burst_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            r_grant       <= w_win_idx;
            r_src_cmd_row <= w_win_idx;
            r_src_cmd_vld <= 1'b1;
            r_state       <= CMD;
          end
        end
        CMD: begin
          if (bus.src_cmd_rdy) begin
            r_src_cmd_vld <= 1'b0;
            r_cnt         <= '0;
            r_state       <= STREAM;
          end
        end
        STREAM: begin
          if (w_beat) begin
            r_row_wr_data <= bus.src_data;
            r_row_wr_vld  <= NUM_ROWS'(1) << r_grant;
            r_cnt         <= r_cnt + 1'b1;
            if (r_cnt == LAST_BEAT) begin
              r_state          <= GAP;
              r_ptr            <= (r_grant == LAST_ROW) ? '0 : r_grant + 1'b1;
              r_burst_done     <= 1'b1;
              r_burst_done_row <= r_grant;
            end
          end
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.row_wr_vld     = r_row_wr_vld;
  assign bus.row_wr_data    = r_row_wr_data;
  assign bus.src_cmd_vld    = r_src_cmd_vld;
  assign bus.src_cmd_row    = r_src_cmd_row;
  assign bus.src_ready      = (r_state == STREAM);
  assign bus.busy           = (r_state != IDLE);
  assign bus.burst_done     = r_burst_done;
  assign bus.burst_done_row = r_burst_done_row;
endmodule
